// File: rtl/sigmoid_sched_pkg.sv
// Shared definitions for the sigmoid scheduler: FSM state encoding,
// default element/lane sizes, the watchdog default and a pointer helper.
package sigmoid_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_S       = 32;
  localparam int DEF_N       = 2;
  localparam int DEF_M       = 4;
  localparam int DEF_TIMEOUT = 64;

  // Next round-robin position after index v, wrapping at m.
  function automatic int wrap_inc(input int v, input int m);
    return (v + 1 >= m) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sigmoid_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit at or
// above ptr, wrapping modulo M. Produces a one-hot grant, its index and a
// flag saying whether anything was granted.
module rr_arbiter #(
  parameter int M  = 4,
  parameter int PW = 2
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [M-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int sel;

  // Scan from ptr upward with wraparound; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sel = 0;
    for (int k = 0; k < M; k++) begin
      sel = (int'(ptr) + k) % M;
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        idx      = PW'(sel);
      end
    end
  end

endmodule

// File: rtl/sigmoid_sched.sv
// Round-robin scheduler sharing one sigmoid unit among M requesters.
// One operation is in flight at a time: capture operand, pulse sig_start,
// wait for a rising edge on sig_done, return the result with a one-hot pulse.
// Optional watchdog: define SIGSCHED_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles; a timed-out operation answers with resp_err=1, resp_y=0.
//
//   state | meaning
//   IDLE  | no operation in flight; arbitrate among pending requests
//   WAIT  | operand launched; waiting for the unit's done edge
module sigmoid_sched
  import sigmoid_sched_pkg::*;
#(
  parameter int S       = DEF_S,
  parameter int N       = DEF_N,
  parameter int M       = DEF_M,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     req,
  input  logic [M*S*N-1:0] req_x,
  output logic [M-1:0]     ack,
  output logic [M-1:0]     resp_valid,
  output logic [S*N-1:0]   resp_y,
  output logic             resp_err,
  output logic             busy,
  output logic [S*N-1:0]   sig_x,
  output logic             sig_start,
  input  logic [S*N-1:0]   sig_y,
  input  logic             sig_done
);

  localparam int W  = S * N;
  localparam int PW = (M > 1) ? $clog2(M) : 1;

  state_t        state;
  logic [PW-1:0] gnt;
  logic [PW-1:0] ptr;
  logic          done_q;
  logic          done_evt;

  logic [M-1:0]  arb_gnt;
  logic [PW-1:0] arb_idx;
  logic          arb_any;

`ifdef SIGSCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wd_cnt;
`endif

  rr_arbiter #(
    .M  (M),
    .PW (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Only a fresh rising edge of done completes an operation; a level left
  // high from an earlier operation is not mistaken for completion.
  assign done_evt = sig_done & ~done_q;

  // Scheduler FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      ptr        <= '0;
      done_q     <= 1'b0;
      ack        <= '0;
      resp_valid <= '0;
      resp_y     <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      sig_x      <= '0;
      sig_start  <= 1'b0;
`ifdef SIGSCHED_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      done_q     <= sig_done;
      ack        <= '0;
      resp_valid <= '0;
      sig_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt       <= arb_idx;
            sig_x     <= req_x[arb_idx*W +: W];
            ack       <= arb_gnt;
            sig_start <= 1'b1;
            busy      <= 1'b1;
            state     <= WAIT;
`ifdef SIGSCHED_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        WAIT: begin
          if (done_evt) begin
            resp_y     <= sig_y;
            resp_valid <= M'(1) << gnt;
            resp_err   <= 1'b0;
            ptr        <= PW'(wrap_inc(int'(gnt), M));
            busy       <= 1'b0;
            state      <= IDLE;
          end
`ifdef SIGSCHED_TIMEOUT_EN
          else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            resp_y     <= '0;
            resp_valid <= M'(1) << gnt;
            resp_err   <= 1'b1;
            ptr        <= PW'(wrap_inc(int'(gnt), M));
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_sched.sv
// Self-checking bench for sigmoid_sched: directed timing sequences, a
// table of arbitration vectors and a randomized run against a round-robin
// reference model. A stub shared unit answers with configurable latency.
module tb_sigmoid_sched;

  localparam int S = 32;
  localparam int N = 2;
  localparam int M = 4;
  localparam int W = S * N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [M-1:0]     req = '0;
  logic [M*W-1:0]   req_x = '0;
  logic [M-1:0]     ack, resp_valid;
  logic [W-1:0]     resp_y, sig_x;
  logic [W-1:0]     sig_y = '0;
  logic             resp_err, busy, sig_start;
  logic             sig_done = 1'b0;

  always #5 clk = ~clk;

  sigmoid_sched #(.S(S), .N(N), .M(M), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .ack        (ack),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .resp_err   (resp_err),
    .busy       (busy),
    .sig_x      (sig_x),
    .sig_start  (sig_start),
    .sig_y      (sig_y),
    .sig_done   (sig_done)
  );

  int vecs = 0;
  int errs = 0;

  // Stub shared unit: after seeing sig_start, raises done for one cycle
  // stub_lat cycles later (0 = never). Can be overridden to force levels.
  int          stub_lat = 5;
  bit          stub_inv = 1'b0;
  bit          stub_force = 1'b0;
  bit          stub_force_val = 1'b0;
  logic [W-1:0] stub_force_y = '0;
  bit          pend = 1'b0;
  int          left = 0;
  logic [W-1:0] px = '0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      pend     = 1'b0;
      sig_done = 1'b0;
    end else if (stub_force) begin
      sig_done = stub_force_val;
      sig_y    = stub_force_y;
    end else if (sig_start && stub_lat > 0) begin
      pend     = 1'b1;
      left     = stub_lat;
      px       = sig_x;
      sig_done = 1'b0;
    end else if (pend) begin
      if (left <= 1) begin
        sig_done = 1'b1;
        sig_y    = stub_inv ? ~px : px;
        pend     = 1'b0;
      end else begin
        left--;
      end
    end else begin
      sig_done = 1'b0;
    end
  end

  // Inputs as the DUT saw them at the last rising edge.
  logic [M-1:0] s_req;
  logic         s_done, s_done_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_req    <= '0;
      s_done   <= 1'b0;
      s_done_q <= 1'b0;
    end else begin
      s_req    <= req;
      s_done   <= sig_done;
      s_done_q <= s_done;
    end
  end

  typedef struct {
    logic [M-1:0] req;
    int           exp_idx;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] onehot(input int i);
    logic [M-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference rule: first requester at or after position p, wrapping.
  function automatic int rr_pick(input logic [M-1:0] r, input int p);
    for (int k = 0; k < M; k++)
      if (r[(p + k) % M]) return (p + k) % M;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_nonzero_ack(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (ack != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_nonzero_resp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (resp_valid != '0) ok = 1'b1;
    end
  endtask

  logic [W-1:0] xs[M];
  logic [W-1:0] op;
  bit           ok;

  initial begin
    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1111, 2};
    tbl[3]  = '{4'b1111, 3};
    tbl[4]  = '{4'b1111, 0};
    tbl[5]  = '{4'b0100, 2};
    tbl[6]  = '{4'b0101, 0};
    tbl[7]  = '{4'b1001, 3};
    tbl[8]  = '{4'b0110, 1};
    tbl[9]  = '{4'b0011, 0};
    tbl[10] = '{4'b1010, 1};
    tbl[11] = '{4'b0001, 0};

    // Reset state
    @(negedge clk);
    chk("rst_ack", ack, '0);
    chk("rst_resp_valid", resp_valid, '0);
    chk("rst_resp_y", resp_y, '0);
    chk("rst_resp_err", resp_err, '0);
    chk("rst_busy", busy, '0);
    chk("rst_sig_x", sig_x, '0);
    chk("rst_sig_start", sig_start, '0);
    rst = 1'b0;

    // Single request, 5-cycle echo latency: ack in cycle 1, response in cycle 7
    stub_lat = 5;
    stub_inv = 1'b0;
    op = 64'h40a00000_c0733333;
    req_x[1*W +: W] = op;
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("single_ack", ack, 4'b0010);
        chk("single_start", sig_start, 1'b1);
        chk("single_busy", busy, 1'b1);
        chk("single_sig_x", sig_x, op);
        req = '0;
      end else if (c < 7) begin
        chk("single_no_resp", resp_valid, '0);
        chk("single_start_low", sig_start, 1'b0);
        chk("single_busy_wait", busy, 1'b1);
      end else if (c == 7) begin
        chk("single_resp_valid", resp_valid, 4'b0010);
        chk("single_resp_y", resp_y, op);
        chk("single_resp_err", resp_err, 1'b0);
        chk("single_busy_fall", busy, 1'b0);
      end else begin
        chk("single_resp_pulse", resp_valid, '0);
      end
    end

    // Table of arbitration vectors (one full operation each)
    do_reset();
    stub_lat = 3;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < M; i++) begin
        xs[i] = {$urandom(), $urandom()};
        req_x[i*W +: W] = xs[i];
      end
      req = tbl[t].req;
      wait_nonzero_ack(ok);
      chk("tbl_ack", ack, onehot(tbl[t].exp_idx));
      req = '0;
      wait_nonzero_resp(ok);
      chk("tbl_resp_valid", resp_valid, onehot(tbl[t].exp_idx));
      chk("tbl_resp_y", resp_y, xs[tbl[t].exp_idx]);
    end

    // Contention with req held: grants 0,1,2,3,0, no launch while busy
    do_reset();
    stub_lat = 2;
    begin
      int  n_acks;
      bit  prev_busy;
      n_acks = 0;
      prev_busy = 1'b0;
      req = 4'b1111;
      for (int c = 0; c < 80 && n_acks < 5; c++) begin
        @(negedge clk);
        if (sig_start) chk("hold_start_overlap", prev_busy, 1'b0);
        if (ack != '0) begin
          chk("hold_ack_order", ack, onehot(n_acks % M));
          n_acks++;
        end
        prev_busy = busy;
      end
      chk("hold_ack_count", n_acks, 5);
      req = '0;
    end

    // Reset two cycles after sig_start; held request is reissued afterwards
    do_reset();
    stub_lat = 5;
    op = {$urandom(), $urandom()};
    req_x[0 +: W] = op;
    req = 4'b0001;
    @(negedge clk);
    chk("rstw_ack", ack, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_ack0", ack, '0);
    chk("rstw_resp_valid", resp_valid, '0);
    chk("rstw_sig_x", sig_x, '0);
    chk("rstw_sig_start", sig_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_reissue_ack", ack, 4'b0001);
    chk("rstw_no_resp", resp_valid, '0);
    req = '0;
    wait_nonzero_resp(ok);
    chk("rstw_resp_valid2", resp_valid, 4'b0001);
    chk("rstw_resp_y2", resp_y, op);

    // Stale done held high: no response until done falls and rises again
    do_reset();
    stub_force_y = 64'h3f000000_3f400000;
    stub_force_val = 1'b1;
    stub_force = 1'b1;
    repeat (3) @(negedge clk);
    req_x[2*W +: W] = {$urandom(), $urandom()};
    req = 4'b0100;
    @(negedge clk);
    chk("stale_ack", ack, 4'b0100);
    req = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stale_no_resp", resp_valid, '0);
    end
    stub_force_val = 1'b0;
    @(negedge clk);
    chk("stale_no_resp_low", resp_valid, '0);
    stub_force_val = 1'b1;
    @(negedge clk);
    chk("stale_resp_valid", resp_valid, 4'b0100);
    chk("stale_resp_y", resp_y, 64'h3f000000_3f400000);
    stub_force = 1'b0;
    @(negedge clk);

`ifdef SIGSCHED_TIMEOUT_EN
    // Watchdog with TIMEOUT=8: unit never answers, error response in cycle 9
    stub_lat = 0;
    req_x[3*W +: W] = {$urandom(), $urandom()};
    req = 4'b1000;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("wd_ack", ack, 4'b1000);
        req = '0;
      end else if (c < 9) begin
        chk("wd_no_resp", resp_valid, '0);
      end else begin
        chk("wd_resp_valid", resp_valid, 4'b1000);
        chk("wd_resp_err", resp_err, 1'b1);
        chk("wd_resp_y", resp_y, '0);
        chk("wd_busy", busy, 1'b0);
      end
    end
`endif

    // Randomized requesters against the round-robin reference model
    do_reset();
    stub_inv = 1'b1;
    stub_lat = 3;
    begin
      int           mptr, mg, g;
      bit           mbusy;
      logic [W-1:0] mexp;
      int           rstate[M];
      logic [W-1:0] rx[M];
      int           pending;
      mptr = 0;
      mg = 0;
      mbusy = 1'b0;
      mexp = '0;
      for (int i = 0; i < M; i++) begin
        rstate[i] = 0;
        rx[i] = '0;
      end
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(negedge clk);
        if (mbusy) begin
          chk("rnd_no_ack_busy", ack, '0);
          if (s_done && !s_done_q) begin
            chk("rnd_resp_valid", resp_valid, onehot(mg));
            chk("rnd_resp_y", resp_y, mexp);
            chk("rnd_resp_err", resp_err, 1'b0);
            mbusy = 1'b0;
            mptr = (mg + 1) % M;
          end else begin
            chk("rnd_no_resp", resp_valid, '0);
          end
        end else begin
          chk("rnd_no_resp_idle", resp_valid, '0);
          if (s_req != '0) begin
            g = rr_pick(s_req, mptr);
            chk("rnd_ack", ack, onehot(g));
            chk("rnd_start", sig_start, 1'b1);
            mbusy = 1'b1;
            mg = g;
            mexp = ~rx[g];
          end else begin
            chk("rnd_no_ack", ack, '0);
          end
        end
        chk("rnd_busy", busy, mbusy);
        for (int i = 0; i < M; i++) begin
          case (rstate[i])
            1: if (ack[i]) begin
                 req[i] = 1'b0;
                 rstate[i] = 2;
               end
            2: if (resp_valid[i]) rstate[i] = 0;
            default: if (cyc < 1200 && $urandom_range(0, 3) == 0) begin
                 rx[i] = {$urandom(), $urandom()};
                 req_x[i*W +: W] = rx[i];
                 req[i] = 1'b1;
                 rstate[i] = 1;
               end
          endcase
        end
        stub_lat = $urandom_range(1, 6);
      end
      pending = 0;
      for (int i = 0; i < M; i++) if (rstate[i] != 0) pending++;
      chk("rnd_drained", pending, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
